// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type built from the shared encodings
package serial_adder_pkg;
`include "serial_adder_defs.vh"
  typedef enum logic [1:0] {
    IDLE = `SA_IDLE,
    RUN  = `SA_RUN,
    DONE = `SA_DONE
  } state_e;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout);
  modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout);
endinterface

// File: rtl/fa.sv
// fa: single-bit full adder
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_defs.vh
// serial_adder_defs: shared state encodings for the serial adder FSM
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
`define SA_IDLE 2'd0
`define SA_RUN  2'd1
`define SA_DONE 2'd2
`endif

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per cycle LSB first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit, c_bit;
  fa u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .sum(s_bit), .cout(c_bit));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        c_d     = cin;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d   = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        c_d     = c_bit;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign sum       = rst ? '0 : sum_q;
  assign cout      = rst ? 1'b0 : c_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random + directed checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(8)) s8 ();
  serial_adder_if #(.WIDTH(1)) s1 ();
  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(s8.in_valid), .in_ready(s8.in_ready), .a(s8.a), .b(s8.b),
    .cin(s8.cin), .out_valid(s8.out_valid), .out_ready(s8.out_ready), .sum(s8.sum), .cout(s8.cout));
  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(s1.in_valid), .in_ready(s1.in_ready), .a(s1.a), .b(s1.b),
    .cin(s1.cin), .out_valid(s1.out_valid), .out_ready(s1.out_ready), .sum(s1.sum), .cout(s1.cout));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: one outstanding addition per DUT, result due WIDTH+1 edges after acceptance (acceptance edge counted).
  bit busy8, busy1;
  int lat8, lat1;
  logic [8:0] exp8, last8;
  logic [1:0] exp1, last1;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready8", 64'(s8.in_ready), 0);
      chk("rst_out_valid8", 64'(s8.out_valid), 0);
      chk("rst_result8", 64'({s8.cout, s8.sum}), 0);
      chk("rst_in_ready1", 64'(s1.in_ready), 0);
      chk("rst_out_valid1", 64'(s1.out_valid), 0);
      chk("rst_result1", 64'({s1.cout, s1.sum}), 0);
      busy8 = 0; busy1 = 0; last8 = '0; last1 = '0;
    end else begin
      if (busy8) lat8++;
      chk("in_ready8", 64'(s8.in_ready), 64'(!busy8));
      chk("out_valid8", 64'(s8.out_valid), 64'(busy8 && lat8 >= 9));
      if (busy8 && lat8 >= 9) chk("result8", 64'({s8.cout, s8.sum}), 64'(exp8));
      else if (!busy8) chk("hold8", 64'({s8.cout, s8.sum}), 64'(last8));
      if (!busy8 && s8.in_valid) begin
        busy8 = 1; lat8 = 0; exp8 = 9'(s8.a) + 9'(s8.b) + 9'(s8.cin);
      end else if (busy8 && lat8 >= 9 && s8.out_ready) begin
        busy8 = 0; last8 = exp8;
      end
      if (busy1) lat1++;
      chk("in_ready1", 64'(s1.in_ready), 64'(!busy1));
      chk("out_valid1", 64'(s1.out_valid), 64'(busy1 && lat1 >= 2));
      if (busy1 && lat1 >= 2) chk("result1", 64'({s1.cout, s1.sum}), 64'(exp1));
      else if (!busy1) chk("hold1", 64'({s1.cout, s1.sum}), 64'(last1));
      if (!busy1 && s1.in_valid) begin
        busy1 = 1; lat1 = 0; exp1 = 2'(s1.a) + 2'(s1.b) + 2'(s1.cin);
      end else if (busy1 && lat1 >= 2 && s1.out_ready) begin
        busy1 = 0; last1 = exp1;
      end
    end
  end
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int stall,
                     input bit junk, input bit lit, input logic [8:0] want);
    int n = 0;
    while (!s8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("timeout_in_ready8", 1, 0);
    s8.in_valid = 1'b1; s8.a = a; s8.b = b; s8.cin = c;
    @(posedge clk); #1;
    s8.in_valid = junk;
    n = 0;
    while (!s8.out_valid && n < 40) begin
      if (junk) begin s8.a = 8'($urandom); s8.b = 8'($urandom); s8.cin = 1'($urandom); end
      @(posedge clk); #1; n++;
    end
    if (n >= 40) chk("timeout_out_valid8", 1, 0);
    s8.in_valid = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    if (lit) chk("literal8", 64'({s8.cout, s8.sum}), 64'(want));
    s8.out_ready = 1'b1;
    @(posedge clk); #1;
    s8.out_ready = 1'b0;
  endtask
  task automatic op1(input logic a, input logic b, input logic c, input bit lit, input logic [1:0] want);
    int n = 0;
    while (!s1.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("timeout_in_ready1", 1, 0);
    s1.in_valid = 1'b1; s1.a = a; s1.b = b; s1.cin = c;
    @(posedge clk); #1;
    s1.in_valid = 1'b0;
    n = 0;
    while (!s1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("timeout_out_valid1", 1, 0);
    if (lit) chk("literal1", 64'({s1.cout, s1.sum}), 64'(want));
    s1.out_ready = 1'b1;
    @(posedge clk); #1;
    s1.out_ready = 1'b0;
  endtask
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  initial begin
    logic [2:0] v;
    s8.in_valid = 0; s8.out_ready = 0; s8.a = '0; s8.b = '0; s8.cin = 0;
    s1.in_valid = 0; s1.out_ready = 0; s1.a = '0; s1.b = '0; s1.cin = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    op8(8'h5A, 8'h3C, 1'b0, 0, 0, 1, 9'h096);
    op8(8'hFF, 8'h01, 1'b0, 0, 0, 1, 9'h100);
    op8(8'hFF, 8'hFF, 1'b1, 0, 0, 1, 9'h1FF);
    op8(8'hA7, 8'h6B, 1'b1, 5, 0, 1, 9'h113);
    op8(8'h12, 8'h34, 1'b1, 0, 1, 1, 9'h047);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      op1(v[2], v[1], v[0], 1, tt[i]);
    end
    s8.in_valid = 1'b1; s8.a = 8'hAA; s8.b = 8'h55; s8.cin = 1'b1;
    @(posedge clk); #1;
    s8.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    op8(8'h01, 8'h01, 1'b0, 0, 0, 1, 9'h002);
    for (int i = 0; i < 60; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 0, '0);
    for (int i = 0; i < 16; i++)
      op1(1'($urandom), 1'($urandom), 1'($urandom), 0, '0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
